// File: rtl/mutative_flush_engine_pkg.sv
// Shared parameters, FSM state encoding and helpers for the mutative cache flush engine.
package mutative_types;

    localparam int unsigned WAYS        = 4;
    localparam int unsigned SET_BITS    = 4;
    localparam int unsigned TAG_BITS    = 23;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned LEVELS      = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        DONE
    } mutative_flush_state_t;

    // Writeback counter stops at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mutative_prio_enc.sv
// Lowest-index priority encoder: reports whether any bit is set and the index of the lowest one.
module mutative_prio_enc #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-1:0]         i_vec,
    output logic                    o_found,
    output logic [$clog2(WAYS)-1:0] o_idx
);

    localparam int unsigned IDX_W = $clog2(WAYS);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        o_found = |i_vec;
        o_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mutative_flush_engine.sv
// Associativity-level reconfiguration controller: applies upgrades at once and sweeps/writes back
// dirty lines before a downgrade takes effect, stalling the cache datapath while it sweeps.
module mutative_flush_engine #(
    parameter int unsigned WAYS        = mutative_types::WAYS,
    parameter int unsigned SET_BITS    = mutative_types::SET_BITS,
    parameter int unsigned TAG_BITS    = mutative_types::TAG_BITS,
    parameter int unsigned OFFSET_BITS = mutative_types::OFFSET_BITS,
    parameter int unsigned LINE_BITS   = mutative_types::LINE_BITS,
    parameter int unsigned LEVELS      = mutative_types::LEVELS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_up,
    output logic [$clog2(LEVELS)-1:0]   level,
    output logic                        busy,
    output logic [WAYS-1:0]             arr_csb,
    output logic [SET_BITS-1:0]         arr_set,
    input  logic [WAYS-1:0]             rd_valid,
    input  logic [WAYS-1:0]             rd_dirty,
    input  logic [WAYS*TAG_BITS-1:0]    rd_tag,
    input  logic [WAYS*LINE_BITS-1:0]   rd_data,
    output logic [WAYS-1:0]             dirty_clr,
    output logic                        dfp_write,
    output logic [31:0]                 dfp_addr,
    output logic [LINE_BITS-1:0]        dfp_wdata,
    input  logic                        dfp_resp,
    output logic [15:0]                 wb_count
);

    localparam int unsigned LVL_W = $clog2(LEVELS);
    localparam int unsigned IDX_W = $clog2(WAYS);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

    mutative_types::mutative_flush_state_t r_state;
    mutative_types::mutative_flush_state_t w_next;

    logic [LVL_W-1:0]     r_level;
    logic [SET_BITS-1:0]  r_set_ctr;
    logic [WAYS-1:0]      r_pending;
    logic [15:0]          r_wb_count;
    logic [TAG_BITS-1:0]  r_snap_tag  [WAYS];
    logic [LINE_BITS-1:0] r_snap_data [WAYS];

    logic                 w_accept;
    logic                 w_sweep_start;
    logic [WAYS-1:0]      w_chk_pending;
    logic                 w_found;
    logic [IDX_W-1:0]     w_way;
    logic [WAYS-1:0]      w_pend_left;
    logic                 w_last_set;
    logic                 w_wb_ack;
    logic                 w_wr_last;

    assign w_accept      = req_valid && (r_state == mutative_types::IDLE);
    assign w_sweep_start = w_accept && !req_up && (r_level != '0);
    assign w_chk_pending = rd_valid & rd_dirty;
    assign w_pend_left   = r_pending & ~(WAYS'(1) << w_way);
    assign w_last_set    = &r_set_ctr;
    assign w_wb_ack      = dfp_resp && w_found;
    // Leave WRITE once the final pending way is acknowledged (or if nothing is pending at all).
    assign w_wr_last     = w_found ? (w_wb_ack && (w_pend_left == '0)) : 1'b1;

    mutative_prio_enc #(
        .WAYS (WAYS)
    ) u_prio_enc (
        .i_vec   (r_pending),
        .o_found (w_found),
        .o_idx   (w_way)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= mutative_types::IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            mutative_types::IDLE: begin
                if (w_sweep_start) begin
                    w_next = mutative_types::READ;
                end
            end
            mutative_types::READ: begin
                w_next = mutative_types::CHECK;
            end
            mutative_types::CHECK: begin
                if (w_chk_pending != '0) begin
                    w_next = mutative_types::WRITE;
                end else if (w_last_set) begin
                    w_next = mutative_types::DONE;
                end else begin
                    w_next = mutative_types::READ;
                end
            end
            mutative_types::WRITE: begin
                if (w_wr_last) begin
                    w_next = w_last_set ? mutative_types::DONE : mutative_types::READ;
                end
            end
            mutative_types::DONE: begin
                w_next = mutative_types::IDLE;
            end
            default: begin
                w_next = mutative_types::IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        arr_csb   = '1;
        arr_set   = r_set_ctr;
        dirty_clr = '0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        case (r_state)
            mutative_types::IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                arr_set   = '0;
            end
            mutative_types::READ: begin
                arr_csb = '0;
            end
            mutative_types::WRITE: begin
                dfp_write = w_found;
                if (w_found) begin
                    dfp_addr  = 32'({r_snap_tag[w_way], r_set_ctr, OFFSET_BITS'(0)});
                    dfp_wdata = r_snap_data[w_way];
                end
                if (w_wb_ack) begin
                    dirty_clr = WAYS'(1) << w_way;
                end
            end
            default: begin
            end
        endcase
    end

    // Level, sweep counter, pending mask and writeback count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level    <= '0;
            r_set_ctr  <= '0;
            r_pending  <= '0;
            r_wb_count <= '0;
        end else begin
            case (r_state)
                mutative_types::IDLE: begin
                    if (w_accept && req_up && (r_level != LVL_MAX)) begin
                        r_level <= r_level + LVL_W'(1);
                    end
                    if (w_sweep_start) begin
                        r_set_ctr  <= '0;
                        r_wb_count <= '0;
                    end
                end
                mutative_types::CHECK: begin
                    r_pending <= w_chk_pending;
                    if ((w_chk_pending == '0) && !w_last_set) begin
                        r_set_ctr <= r_set_ctr + SET_BITS'(1);
                    end
                end
                mutative_types::WRITE: begin
                    if (w_wb_ack) begin
                        r_pending  <= w_pend_left;
                        r_wb_count <= mutative_types::sat_inc16(r_wb_count);
                    end
                    if (w_wr_last && !w_last_set) begin
                        r_set_ctr <= r_set_ctr + SET_BITS'(1);
                    end
                end
                mutative_types::DONE: begin
                    r_level <= r_level - LVL_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Snapshot of the swept set; the cache is stalled so the array read data is stable here.
    always_ff @(posedge clk) begin
        if (r_state == mutative_types::CHECK) begin
            for (int i = 0; i < WAYS; i++) begin
                r_snap_tag[i]  <= rd_tag[i*TAG_BITS +: TAG_BITS];
                r_snap_data[i] <= rd_data[i*LINE_BITS +: LINE_BITS];
            end
        end
    end

    assign level    = r_level;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_mutative_flush_engine.sv
// Scoreboard bench for mutative_flush_engine: models the cache arrays and a DFP with programmable latency.
module tb_mutative_flush_engine;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int TW = 23;
    localparam int LW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_up;
    logic [1:0]      level;
    logic            busy;
    logic [NW-1:0]   arr_csb;
    logic [3:0]      arr_set;
    logic [NW-1:0]   rd_valid;
    logic [NW-1:0]   rd_dirty;
    logic [NW*TW-1:0] rd_tag;
    logic [NW*LW-1:0] rd_data;
    logic [NW-1:0]   dirty_clr;
    logic            dfp_write;
    logic [31:0]     dfp_addr;
    logic [LW-1:0]   dfp_wdata;
    logic            dfp_resp;
    logic [15:0]     wb_count;

    always #5 clk = ~clk;

    mutative_flush_engine dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_up    (req_up),
        .level     (level),
        .busy      (busy),
        .arr_csb   (arr_csb),
        .arr_set   (arr_set),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .dirty_clr (dirty_clr),
        .dfp_write (dfp_write),
        .dfp_addr  (dfp_addr),
        .dfp_wdata (dfp_wdata),
        .dfp_resp  (dfp_resp),
        .wb_count  (wb_count)
    );

    // Cache array model.
    logic          m_valid [NS][NW];
    logic          m_dirty [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    logic [LW-1:0] m_data  [NS][NW];

    always @(posedge clk) begin
        if (arr_csb != 4'hF) begin
            for (int w = 0; w < NW; w++) begin
                rd_valid[w]          <= m_valid[arr_set][w];
                rd_dirty[w]          <= m_dirty[arr_set][w];
                rd_tag[w*TW +: TW]   <= m_tag[arr_set][w];
                rd_data[w*LW +: LW]  <= m_data[arr_set][w];
            end
        end
        for (int w = 0; w < NW; w++) begin
            if (dirty_clr[w]) m_dirty[arr_set][w] <= 1'b0;
        end
    end

    // DFP model: response arrives lat cycles after dfp_write rises.
    int lat;
    int dcnt;
    assign dfp_resp = dfp_write && (dcnt == lat);
    always @(posedge clk) begin
        if (rst || !dfp_write || dfp_resp) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [31:0]   addr;
        logic [LW-1:0] data;
        logic [3:0]    clr;
        logic [3:0]    set;
    } wb_t;
    wb_t sbq[$];

    always @(posedge clk) begin
        if (rst) sbq.delete();
    end

    // Scoreboard monitor: every acknowledged writeback must match the next expected entry.
    always @(negedge clk) begin
        wb_t e;
        if (!rst) begin
            if (dfp_write && dfp_resp) begin
                if (sbq.size() == 0) begin
                    check_eq("wb_unexpected", {224'd0, dfp_addr}, '0);
                end else begin
                    e = sbq.pop_front();
                    check_eq("wb_addr", {224'd0, dfp_addr}, {224'd0, e.addr});
                    check_eq("wb_data", dfp_wdata, e.data);
                    check_eq("wb_clr", {252'd0, dirty_clr}, {252'd0, e.clr});
                    check_eq("wb_set", {252'd0, arr_set}, {252'd0, e.set});
                end
            end else if (dirty_clr != 4'h0) begin
                check_eq("stray_clr", {252'd0, dirty_clr}, '0);
            end
        end
    end

    int exp_level = 0;

    task automatic push_sweep();
        wb_t e;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    e.addr = {m_tag[s][w], 4'(s), 5'd0};
                    e.data = m_data[s][w];
                    e.clr  = 4'(1 << w);
                    e.set  = 4'(s);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic do_req(input logic up);
        @(negedge clk);
        check_eq("req_ready", {255'd0, req_ready}, {255'd0, 1'b1});
        req_valid = 1'b1;
        req_up    = up;
        if (up) begin
            if (exp_level < 3) exp_level++;
        end else if (exp_level > 0) begin
            push_sweep();
            exp_level--;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_sweep(input int exp_busy, input int exp_wb);
        int n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_cycles", LW'(n), LW'(exp_busy));
        check_eq("level", {254'd0, level}, LW'(exp_level));
        check_eq("wb_count", {240'd0, wb_count}, LW'(exp_wb));
        check_eq("sb_left", LW'(sbq.size()), '0);
        check_eq("ready_after", {255'd0, req_ready}, {255'd0, 1'b1});
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_up = 1'b0; lat = 0;
        rd_valid = '0; rd_dirty = '0; rd_tag = '0; rd_data = '0;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b1;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = TW'($urandom);
                m_data[s][w]  = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom};
            end
        end
        repeat (3) @(negedge clk);
        check_eq("rst_level", {254'd0, level}, '0);
        check_eq("rst_busy", {255'd0, busy}, '0);
        check_eq("rst_ready", {255'd0, req_ready}, {255'd0, 1'b1});
        check_eq("rst_csb", {252'd0, arr_csb}, {252'd0, 4'hF});
        check_eq("rst_set", {252'd0, arr_set}, '0);
        check_eq("rst_clr", {252'd0, dirty_clr}, '0);
        check_eq("rst_write", {255'd0, dfp_write}, '0);
        check_eq("rst_addr", {224'd0, dfp_addr}, '0);
        check_eq("rst_wdata", dfp_wdata, '0);
        check_eq("rst_wbc", {240'd0, wb_count}, '0);
        rst = 1'b0;

        // Saturating upgrades: 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1);
            check_eq("up_level", {254'd0, level}, LW'(exp_level));
            check_eq("up_busy", {255'd0, busy}, '0);
        end

        // Clean downgrade 3 -> 2.
        do_req(1'b0);
        wait_sweep(33, 0);

        // Set 5 ways 1 and 3 dirty; set 0 way 2 dirty but invalid. Downgrade 2 -> 1.
        m_tag[5][1] = 23'h12345; m_dirty[5][1] = 1'b1;
        m_tag[5][3] = 23'h54321; m_dirty[5][3] = 1'b1;
        m_valid[0][2] = 1'b0;    m_dirty[0][2] = 1'b1;
        lat = 3;
        do_req(1'b0);
        wait_sweep(33 + 2 * 4, 2);
        check_eq("clr_5_1", {255'd0, m_dirty[5][1]}, '0);
        check_eq("clr_5_3", {255'd0, m_dirty[5][3]}, '0);
        check_eq("keep_0_2", {255'd0, m_dirty[0][2]}, {255'd0, 1'b1});

        // Back-to-back writebacks with zero latency in set 3. Downgrade 1 -> 0.
        m_dirty[3][0] = 1'b1;
        m_dirty[3][2] = 1'b1;
        lat = 0;
        do_req(1'b0);
        wait_sweep(33 + 2 * 1, 2);

        // Downgrade at level 0 is a no-op.
        do_req(1'b0);
        check_eq("l0_busy", {255'd0, busy}, '0);
        check_eq("l0_level", {254'd0, level}, '0);
        check_eq("l0_ready", {255'd0, req_ready}, {255'd0, 1'b1});

        // Reset while a writeback in set 9 is outstanding.
        do_req(1'b1);
        do_req(1'b1);
        m_dirty[9][0] = 1'b1;
        lat = 20;
        do_req(1'b0);
        n = 0;
        while (!dfp_write && n < 500) begin
            n++;
            @(negedge clk);
        end
        check_eq("mid_write", {255'd0, dfp_write}, {255'd0, 1'b1});
        check_eq("mid_set", {252'd0, arr_set}, {252'd0, 4'd9});
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_write", {255'd0, dfp_write}, '0);
        check_eq("mrst_busy", {255'd0, busy}, '0);
        check_eq("mrst_level", {254'd0, level}, '0);
        check_eq("mrst_ready", {255'd0, req_ready}, {255'd0, 1'b1});
        rst = 1'b0;
        exp_level = 0;

        // Fresh sweep restarts from set 0 and finds set 9 still dirty.
        lat = 1;
        do_req(1'b1);
        do_req(1'b0);
        check_eq("fresh_csb", {252'd0, arr_csb}, '0);
        check_eq("fresh_set", {252'd0, arr_set}, '0);
        wait_sweep(33 + 2, 1);
        check_eq("clr_9_0", {255'd0, m_dirty[9][0]}, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
